// File: rtl/btn_toggle_gen.sv
// Debounced push-button front end for a toggle flip-flop.
// Synchronises the raw button level, qualifies each level change over
// DEBOUNCE_CYCLES consecutive samples, emits one t_out pulse per accepted
// press, and keeps a wrapping press counter.
module btn_toggle_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             btn_in,
  output logic             t_out,
  output logic             btn_stable,
  output logic             busy,
  output logic [CNT_W-1:0] press_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the current sample completes qualification.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    HELD      = 2'd2,
    CHK_REL   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             t_out_q, t_out_d;
  logic             stable_q, stable_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  // State, qualification counter and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      t_out_q  <= 1'b0;
      stable_q <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_out_q  <= t_out_d;
      stable_q <= stable_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  // Next-state and next-output decode.
  // The sample that leaves IDLE/HELD is the first qualifying sample, so with
  // DEBOUNCE_CYCLES=1 the level change is accepted on that same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    t_out_d  = 1'b0;
    stable_d = stable_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        stable_d = 1'b0;
        if (btn_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d  = HELD;
            cnt_d    = '0;
            t_out_d  = 1'b1;
            stable_d = 1'b1;
            count_d  = count_q + CNT_W'(1);
          end else begin
            state_d = CHK_PRESS;
            cnt_d   = CNT_ONE;
          end
        end
      end

      CHK_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          t_out_d  = 1'b1;
          stable_d = 1'b1;
          count_d  = count_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HELD: begin
        stable_d = 1'b1;
        if (!btn_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d  = IDLE;
            cnt_d    = '0;
            stable_d = 1'b0;
          end else begin
            state_d = CHK_REL;
            cnt_d   = CNT_ONE;
          end
        end
      end

      CHK_REL: begin
        if (btn_sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          stable_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        stable_d = 1'b0;
      end
    endcase

    busy_d = (state_d == CHK_PRESS) || (state_d == CHK_REL);
  end

  assign t_out       = t_out_q;
  assign btn_stable  = stable_q;
  assign busy        = busy_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_btn_toggle_gen.sv
// Bench for btn_toggle_gen: directed scenarios plus randomized button
// activity compared against a run-length debounce model, on three configs.
module tb_btn_toggle_gen;

  logic clk;
  logic clr;
  logic btn_in;

  logic [2:0] t_v, st_v, bz_v;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  btn_toggle_gen u_a (
    .clk(clk), .clr(clr), .btn_in(btn_in),
    .t_out(t_v[0]), .btn_stable(st_v[0]), .busy(bz_v[0]), .press_count(cnt_a)
  );

  btn_toggle_gen #(.CNT_W(2)) u_b (
    .clk(clk), .clr(clr), .btn_in(btn_in),
    .t_out(t_v[1]), .btn_stable(st_v[1]), .busy(bz_v[1]), .press_count(cnt_b)
  );

  btn_toggle_gen #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(8)) u_c (
    .clk(clk), .clr(clr), .btn_in(btn_in),
    .t_out(t_v[2]), .btn_stable(st_v[2]), .busy(bz_v[2]), .press_count(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream T flip-flop driven by the default instance.
  logic tq = 1'b0;
  always @(posedge clk) tq <= clr ? 1'b0 : (tq ^ t_v[0]);

  // Reference model: a level change is accepted after DEB consecutive
  // synchronised samples that differ from the current debounced level.
  int SYNC_P [3] = '{2, 2, 3};
  int DEB_P  [3] = '{4, 4, 1};
  int CW_P   [3] = '{8, 2, 8};

  int         cyc = 0;
  logic [7:0] hist [3] = '{8'h0, 8'h0, 8'h0};
  logic       m_L  [3] = '{1'b0, 1'b0, 1'b0};
  int         m_r  [3] = '{0, 0, 0};
  int         m_cnt[3] = '{0, 0, 0};
  logic       m_p  [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    logic s, L, p;
    int r, c;
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        hist[i]  <= '0;
        m_L[i]   <= 1'b0;
        m_r[i]   <= 0;
        m_cnt[i] <= 0;
        m_p[i]   <= 1'b0;
      end else begin
        s = hist[i][SYNC_P[i]-1];
        L = m_L[i];
        r = m_r[i];
        c = m_cnt[i];
        p = 1'b0;
        if (s != L) begin
          r = r + 1;
          if (r == DEB_P[i]) begin
            L = s;
            r = 0;
            if (s) begin
              p = 1'b1;
              c = (c + 1) % (1 << CW_P[i]);
            end
          end
        end else begin
          r = 0;
        end
        hist[i]  <= {hist[i][6:0], btn_in};
        m_L[i]   <= L;
        m_r[i]   <= r;
        m_cnt[i] <= c;
        m_p[i]   <= p;
      end
    end
  end

  // Drive one cycle of inputs at the falling edge; return #1 after the next rising edge.
  task automatic tick(input logic b, input logic c);
    @(negedge clk);
    btn_in = b;
    clr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (t_v[i] !== 1'b0) begin failures++; $display("FAIL reset_t_out[%0d] got=%b exp=0", i, t_v[i]); end
      checks++;
      if (st_v[i] !== 1'b0) begin failures++; $display("FAIL reset_btn_stable[%0d] got=%b exp=0", i, st_v[i]); end
      checks++;
      if (bz_v[i] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, bz_v[i]); end
    end
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 2'd0 || cnt_c !== 8'd0) begin
      failures++; $display("FAIL reset_press_count got=%0d/%0d/%0d exp=0/0/0", cnt_a, cnt_b, cnt_c);
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_press();
    int k, np, pc;
    np = 0; pc = -1; k = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      if (i == 0) k = cyc;
      if (t_v[0] === 1'b1) begin np++; pc = cyc; end
    end
    checks++;
    if (np !== 1) begin failures++; $display("FAIL press_pulse_count got=%0d exp=1", np); end
    checks++;
    if (pc !== k + 5) begin failures++; $display("FAIL press_latency got=edge%0d exp=edge%0d", pc, k + 5); end
    checks++;
    if (cnt_a !== 8'd1) begin failures++; $display("FAIL press_count got=%0d exp=1", cnt_a); end
    checks++;
    if (st_v[0] !== 1'b1) begin failures++; $display("FAIL press_stable got=%b exp=1", st_v[0]); end
    checks++;
    if (tq !== 1'b1) begin failures++; $display("FAIL press_tff_q got=%b exp=1", tq); end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int np, st_hi, brise;
    logic prev_b;
    pat = 8'b1110_1101; // applied LSB first: 1,0,1,1,0,1,1,1
    np = 0; st_hi = 0; brise = 0;
    do_reset();
    prev_b = bz_v[0];
    for (int i = 0; i < 18; i++) begin
      tick((i < 8) ? pat[i] : 1'b0, 1'b0);
      if (t_v[0] === 1'b1) np++;
      if (st_v[0] === 1'b1) st_hi++;
      if (bz_v[0] === 1'b1 && prev_b === 1'b0) brise++;
      prev_b = bz_v[0];
    end
    checks++;
    if (np !== 0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", np); end
    checks++;
    if (st_hi !== 0) begin failures++; $display("FAIL bounce_stable_high_cycles got=%0d exp=0", st_hi); end
    checks++;
    if (brise !== 3) begin failures++; $display("FAIL bounce_busy_rises got=%0d exp=3", brise); end
    checks++;
    if (bz_v[0] !== 1'b0) begin failures++; $display("FAIL bounce_busy_final got=%b exp=0", bz_v[0]); end
    checks++;
    if (cnt_a !== 8'd0) begin failures++; $display("FAIL bounce_count got=%0d exp=0", cnt_a); end
  endtask

  task automatic test_release_glitch();
    int np, st_lo, r, fall;
    np = 0; st_lo = 0; fall = -1; r = 0;
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick((i < 2) ? 1'b0 : 1'b1, 1'b0);
      if (t_v[0] === 1'b1) np++;
      if (st_v[0] !== 1'b1) st_lo++;
    end
    checks++;
    if (np !== 0) begin failures++; $display("FAIL glitch_second_pulse got=%0d exp=0", np); end
    checks++;
    if (st_lo !== 0) begin failures++; $display("FAIL glitch_stable_low_cycles got=%0d exp=0", st_lo); end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      if (i == 0) r = cyc;
      if (st_v[0] === 1'b0 && fall < 0) fall = cyc;
    end
    checks++;
    if (fall !== r + 5) begin failures++; $display("FAIL release_latency got=edge%0d exp=edge%0d", fall, r + 5); end
    checks++;
    if (cnt_a !== 8'd1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", cnt_a); end
  endtask

  task automatic test_clr_mid();
    int c, np, pc;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    checks++;
    if (bz_v[0] !== 1'b1) begin failures++; $display("FAIL clr_pre_busy got=%b exp=1", bz_v[0]); end
    for (int pass = 0; pass < 2; pass++) begin
      tick(1'b1, 1'b1);
      c = cyc;
      checks++;
      if (t_v[0] !== 1'b0 || st_v[0] !== 1'b0 || bz_v[0] !== 1'b0 || cnt_a !== 8'd0) begin
        failures++;
        $display("FAIL clr_outputs[%0d] got=t%b s%b b%b c%0d exp=t0 s0 b0 c0", pass, t_v[0], st_v[0], bz_v[0], cnt_a);
      end
      np = 0; pc = -1;
      for (int i = 0; i < 12; i++) begin
        tick(1'b1, 1'b0);
        if (t_v[0] === 1'b1) begin np++; pc = cyc; end
      end
      checks++;
      if (np !== 1 || pc !== c + 6) begin
        failures++;
        $display("FAIL clr_repress[%0d] got=%0d pulses at edge%0d exp=1 at edge%0d", pass, np, pc, c + 6);
      end
      checks++;
      if (cnt_a !== 8'd1) begin failures++; $display("FAIL clr_repress_count[%0d] got=%0d exp=1", pass, cnt_a); end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
      checks++;
      if (cnt_b !== exp_seq[p]) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", p, cnt_b, exp_seq[p]); end
    end
  endtask

  task automatic test_random();
    logic lvl;
    int run;
    logic [7:0] dc, mc;
    lvl = 1'b0; run = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 9));
      end
      run--;
      tick(lvl, ($urandom_range(0, 127) == 0) ? 1'b1 : 1'b0);
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       dc = cnt_a;
          1:       dc = {6'b0, cnt_b};
          default: dc = cnt_c;
        endcase
        mc = 8'(m_cnt[i]);
        checks++;
        if (t_v[i] !== m_p[i]) begin failures++; $display("FAIL rand_t_out[%0d] edge%0d got=%b exp=%b", i, cyc, t_v[i], m_p[i]); end
        checks++;
        if (st_v[i] !== m_L[i]) begin failures++; $display("FAIL rand_btn_stable[%0d] edge%0d got=%b exp=%b", i, cyc, st_v[i], m_L[i]); end
        checks++;
        if (bz_v[i] !== (m_r[i] != 0)) begin failures++; $display("FAIL rand_busy[%0d] edge%0d got=%b exp=%b", i, cyc, bz_v[i], (m_r[i] != 0)); end
        checks++;
        if (dc !== mc) begin failures++; $display("FAIL rand_press_count[%0d] edge%0d got=%0d exp=%0d", i, cyc, dc, mc); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    btn_in = 1'b0;
    clr    = 1'b1;
    test_reset();
    test_press();
    test_bounce();
    test_release_glitch();
    test_clr_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
